// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI-Lite register-file slave.
//   RESP_OKAY / RESP_SLVERR : BRESP/RRESP encodings
//   rd_state_e              : read-channel state machine encoding
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE,
    R_VALID
  } rd_state_e;

endpackage

// File: rtl/axi_lite_addr_decode.sv
// Register-window address decoder (combinational).
//   addr_i : byte address
//   hit_o  : address is word-aligned and inside [BASE_ADDR, BASE_ADDR + 4*NUM_REGS)
//   idx_o  : register index, meaningful only when hit_o is set
module axi_lite_addr_decode
  import axi_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_1000,
  parameter int                    IDX_W      = $clog2(NUM_REGS)
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  hit_o,
  output logic [IDX_W-1:0]      idx_o
);

  // BASE_ADDR is aligned to the window size, so a range check reduces to
  // matching the bits above the window.
  localparam int TAG_LSB = IDX_W + 2;

  assign hit_o = (addr_i[ADDR_WIDTH-1:TAG_LSB] == BASE_ADDR[ADDR_WIDTH-1:TAG_LSB]) &&
                 (addr_i[1:0] == 2'b00);
  assign idx_o = addr_i[TAG_LSB-1:2];

endmodule

// File: rtl/axi_lite_slave_regfile.sv
// AXI-Lite slave exposing NUM_REGS byte-strobed control registers at BASE_ADDR.
//   s_axi_aclk_i / s_axi_areset_i : clock, synchronous active-high reset
//   s_axi_aw* / s_axi_w* / s_axi_b* : write address, data and response channels
//   s_axi_ar* / s_axi_r*            : read address and data channels
//   regs_o                          : flat register contents, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//
// Read FSM:
//   state   | meaning
//   R_IDLE  | arready high, waiting for an AR handshake
//   R_VALID | rvalid high, rdata/rresp held until rready
module axi_lite_slave_regfile
  import axi_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    TRANS_W_STRB_W  = DATA_WIDTH / 8,
  parameter int                    TRANS_WR_RESP_W = 2,
  parameter int                    TRANS_PROT      = 3,
  parameter int                    NUM_REGS        = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 32'h0000_1000
) (
  input  logic                           s_axi_aclk_i,
  input  logic                           s_axi_areset_i,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr_i,
  input  logic [TRANS_PROT-1:0]          s_axi_awprot_i,
  input  logic                           s_axi_awvalid_i,
  output logic                           s_axi_awready_o,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata_i,
  input  logic [TRANS_W_STRB_W-1:0]      s_axi_wstrb_i,
  input  logic                           s_axi_wvalid_i,
  output logic                           s_axi_wready_o,
  output logic [TRANS_WR_RESP_W-1:0]     s_axi_bresp_o,
  output logic                           s_axi_bvalid_o,
  input  logic                           s_axi_bready_i,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr_i,
  input  logic [TRANS_PROT-1:0]          s_axi_arprot_i,
  input  logic                           s_axi_arvalid_i,
  output logic                           s_axi_arready_o,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata_o,
  output logic [TRANS_WR_RESP_W-1:0]     s_axi_rresp_o,
  output logic                           s_axi_rvalid_o,
  input  logic                           s_axi_rready_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic                       aw_full_q, w_full_q;
  logic [ADDR_WIDTH-1:0]      awaddr_q;
  logic [DATA_WIDTH-1:0]      wdata_q;
  logic [TRANS_W_STRB_W-1:0]  wstrb_q;
  logic                       bvalid_q;
  logic [TRANS_WR_RESP_W-1:0] bresp_q;
  rd_state_e                  rstate_q, rstate_d;
  logic [DATA_WIDTH-1:0]      rdata_q;
  logic [TRANS_WR_RESP_W-1:0] rresp_q;
  logic [DATA_WIDTH-1:0]      regs_q [NUM_REGS];

  logic             wr_hit, rd_hit;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             aw_hs, w_hs, ar_hs, commit;

  // Protection bits carry no meaning for this block.
  logic unused_prot;
  assign unused_prot = ^{s_axi_awprot_i, s_axi_arprot_i};

  axi_lite_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .BASE_ADDR  (BASE_ADDR),
    .IDX_W      (IDX_W)
  ) u_wr_decode (
    .addr_i (awaddr_q),
    .hit_o  (wr_hit),
    .idx_o  (wr_idx)
  );

  axi_lite_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .BASE_ADDR  (BASE_ADDR),
    .IDX_W      (IDX_W)
  ) u_rd_decode (
    .addr_i (s_axi_araddr_i),
    .hit_o  (rd_hit),
    .idx_o  (rd_idx)
  );

  assign s_axi_awready_o = !aw_full_q;
  assign s_axi_wready_o  = !w_full_q;
  assign s_axi_bvalid_o  = bvalid_q;
  assign s_axi_bresp_o   = bresp_q;
  assign s_axi_arready_o = (rstate_q == R_IDLE);
  assign s_axi_rvalid_o  = (rstate_q == R_VALID);
  assign s_axi_rdata_o   = rdata_q;
  assign s_axi_rresp_o   = rresp_q;

  assign aw_hs  = s_axi_awvalid_i && !aw_full_q;
  assign w_hs   = s_axi_wvalid_i && !w_full_q;
  assign ar_hs  = s_axi_arvalid_i && (rstate_q == R_IDLE);
  // A commit only fires with B idle, so it never collides with a B handshake,
  // and both slots are full, so it never collides with a slot refill.
  assign commit = aw_full_q && w_full_q && !bvalid_q;

  always_ff @(posedge s_axi_aclk_i) begin
    if (s_axi_areset_i) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
    end else if (commit) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      bvalid_q  <= 1'b1;
      bresp_q   <= wr_hit ? TRANS_WR_RESP_W'(RESP_OKAY) : TRANS_WR_RESP_W'(RESP_SLVERR);
    end else begin
      if (bvalid_q && s_axi_bready_i) bvalid_q <= 1'b0;
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        awaddr_q  <= s_axi_awaddr_i;
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        wdata_q  <= s_axi_wdata_i;
        wstrb_q  <= s_axi_wstrb_i;
      end
    end
  end

  always_ff @(posedge s_axi_aclk_i) begin
    if (s_axi_areset_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (commit && wr_hit) begin
      for (int b = 0; b < TRANS_W_STRB_W; b++) begin
        if (wstrb_q[b]) regs_q[wr_idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge s_axi_aclk_i) begin
    if (s_axi_areset_i) begin
      rstate_q <= R_IDLE;
      rdata_q  <= '0;
      rresp_q  <= '0;
    end else begin
      rstate_q <= rstate_d;
      // Sampled before this edge's commit lands, so a same-edge write is not seen.
      if (ar_hs) begin
        rdata_q <= rd_hit ? regs_q[rd_idx] : '0;
        rresp_q <= rd_hit ? TRANS_WR_RESP_W'(RESP_OKAY) : TRANS_WR_RESP_W'(RESP_SLVERR);
      end
    end
  end

  always_comb begin
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE:  if (s_axi_arvalid_i) rstate_d = R_VALID;
      R_VALID: if (s_axi_rready_i)  rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
    assign regs_o[gi*DATA_WIDTH +: DATA_WIDTH] = regs_q[gi];
  end

endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
module tb_axi_lite_slave_regfile;

  localparam int          NR   = 16;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   awaddr, wdata, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, wvalid, arvalid, bready, rready;
  logic [3:0]    wstrb;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata;
  logic [NR*32-1:0] regs_o;

  always #5 clk = ~clk;

  axi_lite_slave_regfile dut (
    .s_axi_aclk_i    (clk),
    .s_axi_areset_i  (rst),
    .s_axi_awaddr_i  (awaddr),
    .s_axi_awprot_i  (awprot),
    .s_axi_awvalid_i (awvalid),
    .s_axi_awready_o (awready),
    .s_axi_wdata_i   (wdata),
    .s_axi_wstrb_i   (wstrb),
    .s_axi_wvalid_i  (wvalid),
    .s_axi_wready_o  (wready),
    .s_axi_bresp_o   (bresp),
    .s_axi_bvalid_o  (bvalid),
    .s_axi_bready_i  (bready),
    .s_axi_araddr_i  (araddr),
    .s_axi_arprot_i  (arprot),
    .s_axi_arvalid_i (arvalid),
    .s_axi_arready_o (arready),
    .s_axi_rdata_o   (rdata),
    .s_axi_rresp_o   (rresp),
    .s_axi_rvalid_o  (rvalid),
    .s_axi_rready_i  (rready),
    .regs_o          (regs_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct { logic [31:0] d; logic [3:0] s; } wbeat_t;

  logic [31:0] m_mem [NR];
  logic [31:0] m_awq [$];
  wbeat_t      m_wq  [$];
  bit          m_bvalid, m_rvalid, m_live = 1'b0;
  logic [1:0]  m_bresp, m_rresp;
  logic [31:0] m_rdata;
  bit          aw_acc, w_acc, ar_acc;

  function automatic bit m_hit(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 * NR)) && (a % 4 == 0);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  always @(posedge clk) begin
    bit commit, aw_room, w_room;
    logic [31:0] a;
    wbeat_t w;
    aw_acc = 0; w_acc = 0; ar_acc = 0;
    if (rst) begin
      m_live = 1'b1;
      for (int i = 0; i < NR; i++) m_mem[i] = '0;
      m_awq.delete(); m_wq.delete();
      m_bvalid = 0; m_rvalid = 0;
      m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0;
    end else if (m_live) begin
      aw_room = (m_awq.size() == 0);
      w_room  = (m_wq.size() == 0);
      commit  = (m_awq.size() > 0) && (m_wq.size() > 0) && !m_bvalid;
      // read sees contents from before any write on this edge
      if (m_rvalid) begin
        if (rready) m_rvalid = 0;
      end else if (arvalid) begin
        ar_acc   = 1;
        m_rvalid = 1;
        m_rdata  = m_hit(araddr) ? m_mem[m_idx(araddr)] : 32'h0;
        m_rresp  = m_hit(araddr) ? 2'b00 : 2'b10;
      end
      if (m_bvalid && bready) m_bvalid = 0;
      if (commit) begin
        a = m_awq.pop_front();
        w = m_wq.pop_front();
        if (m_hit(a))
          for (int b = 0; b < 4; b++)
            if (w.s[b]) m_mem[m_idx(a)][b*8 +: 8] = w.d[b*8 +: 8];
        m_bvalid = 1;
        m_bresp  = m_hit(a) ? 2'b00 : 2'b10;
      end
      if (aw_room && awvalid) begin m_awq.push_back(awaddr); aw_acc = 1; end
      if (w_room && wvalid) begin
        w.d = wdata; w.s = wstrb;
        m_wq.push_back(w); w_acc = 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [NR*32-1:0] exp_flat;
    if (m_live) begin
      for (int i = 0; i < NR; i++) exp_flat[i*32 +: 32] = m_mem[i];
      check("awready", awready, m_awq.size() == 0);
      check("wready",  wready,  m_wq.size() == 0);
      check("arready", arready, !m_rvalid);
      check("bvalid",  bvalid,  m_bvalid);
      check("rvalid",  rvalid,  m_rvalid);
      if (m_bvalid) check("bresp", bresp, m_bresp);
      if (m_rvalid) begin
        check("rdata", rdata, m_rdata);
        check("rresp", rresp, m_rresp);
      end
      check("regs_o", regs_o, exp_flat);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [31:0] reg_of(input int i);
    return regs_o[i*32 +: 32];
  endfunction

  // AW and W together, commit on the next edge, B consumed on the one after (bready=1).
  task automatic write_both(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    awvalid = 1; awaddr = a; wvalid = 1; wdata = d; wstrb = s;
    step();
    awvalid = 0; wvalid = 0;
    step();
    step();
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 32'h0000_2000;
      1:       return BASE + 32'($urandom_range(0, NR - 1) * 4) + 32'($urandom_range(1, 3));
      2:       return 32'h0000_0FFC;
      3:       return 32'h0000_1040;
      default: return BASE + 32'($urandom_range(0, NR - 1) * 4);
    endcase
  endfunction

  initial begin
    rst = 1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0; awprot = '0; arprot = '0;
    repeat (3) step();
    check("rst_awready", awready, 1'b1);
    check("rst_wready",  wready,  1'b1);
    check("rst_arready", arready, 1'b1);
    check("rst_bvalid",  bvalid,  1'b0);
    check("rst_rvalid",  rvalid,  1'b0);
    check("rst_regs",    regs_o,  '0);
    rst = 0;
    step();
    check("post_rst_bresp", bresp, 2'b00);
    check("post_rst_rdata", rdata, 32'h0);

    // 1: simultaneous AW+W, then read back
    awvalid = 1; awaddr = 32'h1004; wvalid = 1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
    step();
    check("t1_awready_full", awready, 1'b0);
    check("t1_bvalid_early", bvalid, 1'b0);
    awvalid = 0; wvalid = 0;
    step();
    check("t1_bvalid", bvalid, 1'b1);
    check("t1_bresp",  bresp,  2'b00);
    check("t1_reg1",   reg_of(1), 32'hDEAD_BEEF);
    step();
    rready = 0; arvalid = 1; araddr = 32'h1004;
    step();
    check("t1_rvalid", rvalid, 1'b1);
    check("t1_rdata",  rdata,  32'hDEAD_BEEF);
    check("t1_rresp",  rresp,  2'b00);
    arvalid = 0; rready = 1;
    step();
    check("t1_rvalid_clr", rvalid, 1'b0);

    // 2: W three cycles ahead of AW, partial strobe
    write_both(32'h1008, 32'hFFFF_FFFF, 4'hF);
    check("t2_preload", reg_of(2), 32'hFFFF_FFFF);
    wvalid = 1; wdata = 32'h1234_5678; wstrb = 4'b0011;
    step();
    check("t2_wready_full", wready, 1'b0);
    wvalid = 0;
    step(); step();
    check("t2_no_commit", reg_of(2), 32'hFFFF_FFFF);
    awvalid = 1; awaddr = 32'h1008;
    step();
    check("t2_bvalid_at_aw", bvalid, 1'b0);
    awvalid = 0;
    step();
    check("t2_bvalid", bvalid, 1'b1);
    check("t2_reg2",   reg_of(2), 32'hFFFF_5678);
    check("t2_model",  m_mem[2],  32'hFFFF_5678);
    step();

    // 3: unmapped write, misaligned read
    awvalid = 1; awaddr = 32'h2000; wvalid = 1; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
    step();
    awvalid = 0; wvalid = 0;
    step();
    check("t3_bresp", bresp, 2'b10);
    step();
    rready = 0; arvalid = 1; araddr = 32'h1002;
    step();
    check("t3_rresp", rresp, 2'b10);
    check("t3_rdata", rdata, 32'h0);
    arvalid = 0; rready = 1;
    step();
    check("t3_reg0", reg_of(0), 32'h0);
    check("t3_reg1", reg_of(1), 32'hDEAD_BEEF);
    check("t3_reg2", reg_of(2), 32'hFFFF_5678);

    // 4: B backpressure with a second write queued behind it
    bready = 0;
    awvalid = 1; awaddr = 32'h100C; wvalid = 1; wdata = 32'h1111_1111; wstrb = 4'hF;
    step();
    awvalid = 0; wvalid = 0;
    step();
    for (int i = 0; i < 5; i++) begin
      check("t4_bvalid_hold", bvalid, 1'b1);
      check("t4_bresp_hold",  bresp,  2'b00);
      step();
    end
    check("t4_awready_pre", awready, 1'b1);
    check("t4_wready_pre",  wready,  1'b1);
    awvalid = 1; awaddr = 32'h1010; wvalid = 1; wdata = 32'h2222_2222;
    step();
    check("t4_awready_post", awready, 1'b0);
    check("t4_wready_post",  wready,  1'b0);
    awvalid = 0; wvalid = 0;
    step(); step();
    check("t4_bvalid_still", bvalid, 1'b1);
    check("t4_reg4_wait",    reg_of(4), 32'h0);
    bready = 1;
    step();
    check("t4_bvalid_gap", bvalid, 1'b0);
    check("t4_reg4_gap",   reg_of(4), 32'h0);
    step();
    check("t4_bvalid2", bvalid, 1'b1);
    check("t4_reg4",    reg_of(4), 32'h2222_2222);
    check("t4_reg3",    reg_of(3), 32'h1111_1111);
    step();

    // 5: read racing a commit to the same register
    write_both(32'h1000, 32'hAAAA_AAAA, 4'hF);
    awvalid = 1; awaddr = 32'h1000; wvalid = 1; wdata = 32'h5555_5555; wstrb = 4'hF;
    step();
    awvalid = 0; wvalid = 0;
    rready = 0; arvalid = 1; araddr = 32'h1000;
    step();
    check("t5_rdata_old", rdata, 32'hAAAA_AAAA);
    check("t5_reg0_new",  reg_of(0), 32'h5555_5555);
    arvalid = 0; rready = 1;
    step();
    rready = 0; arvalid = 1;
    step();
    check("t5_rdata_new", rdata, 32'h5555_5555);
    arvalid = 0; rready = 1;
    step();

    // 6: reset with B and R pending and a held AW slot
    bready = 0; rready = 0;
    awvalid = 1; awaddr = 32'h1004; wvalid = 1; wdata = 32'h0BAD_0BAD; wstrb = 4'hF;
    step();
    awvalid = 0; wvalid = 0;
    step();
    arvalid = 1; araddr = 32'h1000;
    step();
    arvalid = 0; awvalid = 1; awaddr = 32'h1008;
    step();
    awvalid = 0;
    check("t6_bvalid_pre",  bvalid,  1'b1);
    check("t6_rvalid_pre",  rvalid,  1'b1);
    check("t6_awready_pre", awready, 1'b0);
    rst = 1;
    step();
    check("t6_bvalid", bvalid, 1'b0);
    check("t6_rvalid", rvalid, 1'b0);
    check("t6_regs",   regs_o, '0);
    check("t6_awready", awready, 1'b1);
    check("t6_wready",  wready,  1'b1);
    check("t6_arready", arready, 1'b1);
    rst = 0; bready = 1; rready = 1;
    step();

    // randomized traffic, valids held until the model reports acceptance
    for (int n = 0; n < 4000; n++) begin
      if (awvalid && aw_acc) awvalid = 0;
      if (wvalid && w_acc)   wvalid  = 0;
      if (arvalid && ar_acc) arvalid = 0;
      if (!awvalid && $urandom_range(0, 1) == 1) begin
        awvalid = 1; awaddr = rand_addr(); awprot = 3'($urandom);
      end
      if (!wvalid && $urandom_range(0, 1) == 1) begin
        wvalid = 1; wdata = $urandom; wstrb = 4'($urandom);
      end
      if (!arvalid && $urandom_range(0, 1) == 1) begin
        arvalid = 1; araddr = rand_addr(); arprot = 3'($urandom);
      end
      bready = ($urandom_range(0, 3) != 0);
      rready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 399) == 0);
      if (rst) begin awvalid = 0; wvalid = 0; arvalid = 0; end
      step();
    end
    rst = 0; awvalid = 0; wvalid = 0; arvalid = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_slave_regfile.md
# axi_lite_slave_regfile

Downstream AXI-Lite slave that terminates the single slave port of `axi_interconnect_n_1`. It provides NUM_REGS byte-strobed 32-bit control registers at BASE_ADDR. It accepts AW and W independently, commits each write once both halves are held, and returns one B response per write and one R beat per read. Unmapped or misaligned accesses complete with SLVERR and have no side effects.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data/register width
- TRANS_W_STRB_W, 4, write strobe width (DATA_WIDTH/8)
- TRANS_WR_RESP_W, 2, BRESP/RRESP width
- TRANS_PROT, 3, AxPROT width (accepted, ignored)
- NUM_REGS, 16, register count (power of two, ≥2)
- BASE_ADDR, 32'h0000_1000, byte address of register 0 (NUM_REGS*4 aligned)

Ports:
- s_axi_aclk_i  in  1  clock; everything is on the rising edge
- s_axi_areset_i  in  1  reset; synchronous and active-high
- s_axi_awaddr_i / s_axi_awprot_i / s_axi_awvalid_i  in  ADDR_WIDTH/TRANS_PROT/1  write address
- s_axi_awready_o  out  1
- s_axi_wdata_i / s_axi_wstrb_i / s_axi_wvalid_i  in  DATA_WIDTH/TRANS_W_STRB_W/1  write data
- s_axi_wready_o  out  1
- s_axi_bresp_o / s_axi_bvalid_o  out  TRANS_WR_RESP_W/1  write response
- s_axi_bready_i  in  1
- s_axi_araddr_i / s_axi_arprot_i / s_axi_arvalid_i  in  ADDR_WIDTH/TRANS_PROT/1  read address
- s_axi_arready_o  out  1
- s_axi_rdata_o / s_axi_rresp_o / s_axi_rvalid_o  out  DATA_WIDTH/TRANS_WR_RESP_W/1  read data
- s_axi_rready_i  in  1
- regs_o  out  NUM_REGS*DATA_WIDTH  flat register contents; register i is at [i*DATA_WIDTH +: DATA_WIDTH]

## Operation
- Decode: hit when the address is in [BASE_ADDR, BASE_ADDR+4*NUM_REGS) and addr[1:0]==0. Index = (addr-BASE_ADDR)>>2. A miss gives RESP = SLVERR (2'b10); a hit gives OKAY (2'b00).
- Write path: two one-deep holding slots, aw_full and w_full.
  - s_axi_awready_o = !aw_full and s_axi_wready_o = !w_full.
  - On a handshake, the slot latches the address or the data+strobe.
- Commit: when aw_full && w_full && !s_axi_bvalid_o:
  - On a hit, write each byte lane whose strobe is 1.
  - Set bvalid, load bresp, and clear both slots.
- B: bvalid is held with bresp stable until s_axi_bready_i. Both slots may refill while B is pending. The next commit waits for B to clear.
- Read FSM has states R_IDLE and R_VALID.
  - s_axi_arready_o = (state == R_IDLE).
  - An AR handshake latches rdata (register value on a hit, 0 on a miss) and rresp, then moves to R_VALID.
  - R_VALID with s_axi_rready_i returns to R_IDLE.
- AxPROT is ignored. Read and write paths are independent.

## Timing
- While reset is high and on the first cycle after it: bvalid, rvalid, bresp, rresp, rdata = 0. aw_full = w_full = 0, so awready = wready = arready = 1 (AXI permits ready high in reset). All registers in regs_o = 0.
- Write latency: AW and W both handshake at edge N → register and regs_o update at edge N+1, and bvalid is high from N+1.
- AW at edge N and W at edge N+k → commit at N+k+1.
- Read latency: AR handshake at edge N → rvalid high from N; the earliest next AR handshake is the edge after the R handshake.
- Commit and AR to the same register at the same edge → R returns the pre-write value.
- Backpressure: bready/rready low → valid and payload stay stable indefinitely; awready and wready drop once their slot fills.
- Reset mid-transaction: held slots and pending B/R are discarded with no response, and registers clear.
- strb = 0 on a hit: no bytes change; bresp = OKAY.

## Structure
- Package `axi_lite_pkg`:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10
  - read FSM state enum {R_IDLE, R_VALID}
- Sub-module `axi_lite_addr_decode` (combinational: addr → hit, index). Instantiated twice, once on the held AW address and once on araddr.

## Test plan
- Write 0x1004 = DEAD_BEEF, strb 1111, AW and W at the same edge, bready=1 → bvalid one cycle later with bresp 00; register 1 = DEAD_BEEF; read of 0x1004 returns DEAD_BEEF/00.
- W three cycles before AW, strb 0011, data 1234_5678 to 0x1008 (register 2 preloaded FFFF_FFFF) → wready low after the W handshake; commit on the edge after AW; register 2 = FFFF_5678.
- Write to 0x2000 and read from 0x1002 → bresp 10, rresp 10, rdata 0; no register changes.
- Hold bready=0 for 5 cycles after a write, then present a second AW+W → both accepted (awready/wready 1 then 0); bvalid/bresp stay stable; second commit happens one cycle after the first B handshake.
- AR at the same edge a write commits to register 0 (old AAAA_AAAA, new 5555_5555) → rdata AAAA_AAAA; the following read returns 5555_5555.
- Assert reset while bvalid=1 and rvalid=1 → both valids 0 on the next edge, regs_o all zero, all readys 1.
